// File: rtl/dt_stats.sv
// Distance-map statistics: raster-scans the result RAM once per start request and
// reports peak value, first peak address, nonzero pixel count and value sum.
module dt_stats #(
    parameter int N_PIX = 16384
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        res_rd,
    output logic [13:0] res_addr,
    input  logic [7:0]  res_di,
    output logic [7:0]  max_val,
    output logic [13:0] max_addr,
    output logic [14:0] obj_cnt,
    output logic [21:0] dist_sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_e;

    localparam logic [13:0] LAST_ADDR = 14'(N_PIX - 1);

    state_e      state_q, state_d;
    logic [13:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        res_rd_q, res_rd_d;
    logic [7:0]  max_val_q, max_val_d;
    logic [13:0] max_addr_q, max_addr_d;
    logic [14:0] obj_cnt_q, obj_cnt_d;
    logic [21:0] dist_sum_q, dist_sum_d;

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        max_val_d  = max_val_q;
        max_addr_d = max_addr_q;
        obj_cnt_d  = obj_cnt_q;
        dist_sum_d = dist_sum_q;

        // Sample arriving now belongs to the address still held in addr_q.
        if (valid_q) begin
            obj_cnt_d  = obj_cnt_q + 15'(res_di != 8'd0);
            dist_sum_d = dist_sum_q + 22'(res_di);
            if (res_di > max_val_q) begin
                max_val_d  = res_di;
                max_addr_d = addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_SCAN;
                    addr_d     = 14'd0;
                    max_val_d  = 8'd0;
                    max_addr_d = 14'd0;
                    obj_cnt_d  = 15'd0;
                    dist_sum_d = 22'd0;
                end
            end
            S_SCAN: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_q + 14'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // An address is issued on every cycle spent in SCAN; its data lands one edge later.
        valid_d  = (state_d == S_SCAN);
        busy_d   = (state_d == S_SCAN);
        res_rd_d = (state_d == S_SCAN);
        done_d   = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            addr_q     <= 14'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            res_rd_q   <= 1'b0;
            max_val_q  <= 8'd0;
            max_addr_q <= 14'd0;
            obj_cnt_q  <= 15'd0;
            dist_sum_q <= 22'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            res_rd_q   <= res_rd_d;
            max_val_q  <= max_val_d;
            max_addr_q <= max_addr_d;
            obj_cnt_q  <= obj_cnt_d;
            dist_sum_q <= dist_sum_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign res_rd   = res_rd_q;
    assign res_addr = addr_q;
    assign max_val  = max_val_q;
    assign max_addr = max_addr_q;
    assign obj_cnt  = obj_cnt_q;
    assign dist_sum = dist_sum_q;

endmodule

// File: tb/tb_dt_stats.sv
// Directed bench for dt_stats: behavioural result RAM, hand-computed maps and a
// chessboard-distance map whose statistics come from a small software model.
module tb_dt_stats;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic [7:0]  max_val;
    logic [13:0] max_addr;
    logic [14:0] obj_cnt;
    logic [21:0] dist_sum;

    logic [7:0]  mem [N];

    int checks = 0;
    int errors = 0;

    dt_stats #(.N_PIX(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_di   (res_di),
        .max_val  (max_val),
        .max_addr (max_addr),
        .obj_cnt  (obj_cnt),
        .dist_sum (dist_sum)
    );

    always #5 clk = ~clk;

    // Result RAM: address taken on the falling edge, data ready before the next rising edge.
    always @(negedge clk) begin
        if (res_rd) res_di = mem[res_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    task automatic check_results(input string tag, input int mv, input int ma, input int oc, input int ds);
        check({tag, ":max_val"},  32'(max_val),  32'(mv));
        check({tag, ":max_addr"}, 32'(max_addr), 32'(ma));
        check({tag, ":obj_cnt"},  32'(obj_cnt),  32'(oc));
        check({tag, ":dist_sum"}, 32'(dist_sum), 32'(ds));
    endtask

    // Full scan with bounded wait; ignore_at >= 0 pulses start again at that cycle.
    task automatic run_scan(input string tag, input int ignore_at);
        int lat;
        int rd_cnt;
        int addr_err;
        logic busy_at_done;
        logic rd_at_done;
        lat = -1;
        rd_cnt = 0;
        addr_err = 0;
        busy_at_done = 1'bx;
        rd_at_done = 1'bx;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 0; cyc < N + 100; cyc++) begin
            if (res_rd === 1'b1) begin
                if (res_addr !== 14'(rd_cnt)) addr_err++;
                rd_cnt++;
            end
            if (done === 1'b1) begin
                lat = cyc;
                busy_at_done = busy;
                rd_at_done = res_rd;
                break;
            end
            if (cyc == ignore_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
        end
        check({tag, ":latency"},      32'(lat),      32'(N));
        check({tag, ":rd_cycles"},    32'(rd_cnt),   32'(N));
        check({tag, ":addr_seq_err"}, 32'(addr_err), 32'd0);
        check({tag, ":busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({tag, ":rd_at_done"},   32'(rd_at_done),   32'd0);
        @(posedge clk);
        #1;
        check({tag, ":done_one_cycle"}, 32'(done), 32'd0);
    endtask

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Chessboard distance inside a rectangle; 0 outside.
    function automatic int rect_dt(input int r, input int c, input int r0, input int r1,
                                   input int c0, input int c1);
        if (r < r0 || r > r1 || c < c0 || c > c1) return 0;
        return min2(min2(r - r0 + 1, r1 - r + 1), min2(c - c0 + 1, c1 - c + 1));
    endfunction

    initial begin
        int exp_max;
        int exp_addr;
        int exp_cnt;
        int exp_sum;
        int done_seen;

        reset = 1'b0;
        start = 1'b0;
        res_di = 8'd0;
        fill(8'd0);
        #12;
        check("rst:busy",     32'(busy),     32'd0);
        check("rst:done",     32'(done),     32'd0);
        check("rst:res_rd",   32'(res_rd),   32'd0);
        check("rst:res_addr", 32'(res_addr), 32'd0);
        check_results("rst", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle:busy", 32'(busy), 32'd0);

        // All-zero map.
        run_scan("zero", -1);
        check_results("zero", 0, 0, 0, 0);

        // Single pixel, with a second start mid-scan that must be ignored.
        fill(8'd0);
        mem[8321] = 8'h2A;
        run_scan("single", 5000);
        check_results("single", 8'h2A, 8321, 1, 42);

        // Two equal peaks: first in raster order wins.
        fill(8'd0);
        mem[300]  = 8'h05;
        mem[9000] = 8'h05;
        mem[100]  = 8'h03;
        run_scan("peaks", -1);
        check_results("peaks", 5, 300, 3, 13);

        // Saturated map: widest accumulator values.
        fill(8'hFF);
        run_scan("full", -1);
        check_results("full", 255, 0, 16384, 4177920);

        // Reset mid-scan: partial results visible, then cleared asynchronously.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7000) @(posedge clk);
        #1;
        check("abort:partial_cnt", 32'(obj_cnt),  32'd7000);
        check("abort:partial_sum", 32'(dist_sum), 32'd1785000);
        #2 reset = 1'b0;
        #1;
        check("abort:busy",     32'(busy),     32'd0);
        check("abort:res_rd",   32'(res_rd),   32'd0);
        check("abort:res_addr", 32'(res_addr), 32'd0);
        check_results("abort", 0, 0, 0, 0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (done === 1'b1) done_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (done === 1'b1 || busy === 1'b1) done_seen++;
        end
        check("abort:no_done", 32'(done_seen), 32'd0);

        // Distance map of two rectangular objects; statistics from a software model.
        for (int r = 0; r < 128; r++) begin
            for (int c = 0; c < 128; c++) begin
                mem[r * 128 + c] = 8'(rect_dt(r, c, 20, 59, 30, 99) + rect_dt(r, c, 80, 120, 10, 40));
            end
        end
        exp_max = 0;
        exp_addr = 0;
        exp_cnt = 0;
        exp_sum = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] != 8'd0) exp_cnt++;
            exp_sum += int'(mem[i]);
            if (int'(mem[i]) > exp_max) begin
                exp_max = int'(mem[i]);
                exp_addr = i;
            end
        end
        run_scan("dtmap", -1);
        check_results("dtmap", exp_max, exp_addr, exp_cnt, exp_sum);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
